// File: rtl/snake_game_tick.sv
// Game-logic side of the snake frame interface: on every drawn-frame end it latches a direction,
// steps the head one cell, checks walls and commits. Define SNAKE_WRAP_EN to wrap at the edges instead.
module snake_game_tick #(
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int START_X    = 20,
    parameter int START_Y    = 15,
    parameter int PLAY_STAGE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        isDrawing,
    input  logic [31:0] rstage,
    input  logic [1:0]  dirIn,
    output logic [5:0]  headX,
    output logic [5:0]  headY,
    output logic [1:0]  dir,
    output logic [15:0] tickCount,
    output logic        gameOver,
    output logic        updating
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        MOVE   = 3'd2,
        CHECK  = 3'd3,
        COMMIT = 3'd4
    } state_t;

    localparam logic [6:0]  GRID_W7    = 7'(GRID_W);
    localparam logic [6:0]  GRID_H7    = 7'(GRID_H);
    localparam logic [5:0]  START_X6   = 6'(START_X);
    localparam logic [5:0]  START_Y6   = 6'(START_Y);
    localparam logic [31:0] PLAY_STG32 = 32'(PLAY_STAGE);

    state_t      state_q, state_d;
    logic        is_drawing_q, is_drawing_d;
    logic [5:0]  head_x_q, head_x_d;
    logic [5:0]  head_y_q, head_y_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  next_dir_q, next_dir_d;
    logic [6:0]  cand_x_q, cand_x_d;
    logic [6:0]  cand_y_q, cand_y_d;
    logic        hit_wall_q, hit_wall_d;
    logic [15:0] tick_count_q, tick_count_d;
    logic        game_over_q, game_over_d;
    logic        updating_q, updating_d;
    logic        frame_end;
    logic [6:0]  step_x, step_y;

    assign frame_end = is_drawing_q & ~isDrawing;

    always_comb begin
        state_d      = state_q;
        is_drawing_d = isDrawing;
        head_x_d     = head_x_q;
        head_y_d     = head_y_q;
        dir_d        = dir_q;
        next_dir_d   = next_dir_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        hit_wall_d   = hit_wall_q;
        tick_count_d = tick_count_q;
        game_over_d  = game_over_q;
        step_x       = {1'b0, head_x_q};
        step_y       = {1'b0, head_y_q};

        case (state_q)
            IDLE: begin
                if (frame_end) begin
                    if (rstage == 32'd0) begin
                        head_x_d     = START_X6;
                        head_y_d     = START_Y6;
                        dir_d        = 2'd1;
                        tick_count_d = 16'd0;
                        game_over_d  = 1'b0;
                    end else if (rstage == PLAY_STG32 && !game_over_q) begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                // A request to turn straight back is treated as "keep going".
                next_dir_d = (dirIn == (dir_q ^ 2'd2)) ? dir_q : dirIn;
                state_d    = MOVE;
            end
            MOVE: begin
                // 7-bit arithmetic: stepping left/up from 0 yields 7'h7F, visible as negative.
                case (next_dir_q)
                    2'd0:    step_y = step_y - 7'd1;
                    2'd1:    step_x = step_x + 7'd1;
                    2'd2:    step_y = step_y + 7'd1;
                    default: step_x = step_x - 7'd1;
                endcase
`ifdef SNAKE_WRAP_EN
                if (step_x == 7'h7F)        step_x = GRID_W7 - 7'd1;
                else if (step_x == GRID_W7) step_x = 7'd0;
                if (step_y == 7'h7F)        step_y = GRID_H7 - 7'd1;
                else if (step_y == GRID_H7) step_y = 7'd0;
`endif
                cand_x_d = step_x;
                cand_y_d = step_y;
                state_d  = CHECK;
            end
            CHECK: begin
`ifdef SNAKE_WRAP_EN
                hit_wall_d = 1'b0;
`else
                hit_wall_d = cand_x_q[6] || (cand_x_q >= GRID_W7) ||
                             cand_y_q[6] || (cand_y_q >= GRID_H7);
`endif
                state_d = COMMIT;
            end
            COMMIT: begin
                if (hit_wall_q) begin
                    game_over_d = 1'b1;
                end else begin
                    head_x_d = cand_x_q[5:0];
                    head_y_d = cand_y_q[5:0];
                    dir_d    = next_dir_q;
                end
                if (tick_count_q != 16'hFFFF) tick_count_d = tick_count_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        updating_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            is_drawing_q <= 1'b0;
            head_x_q     <= START_X6;
            head_y_q     <= START_Y6;
            dir_q        <= 2'd1;
            next_dir_q   <= 2'd1;
            cand_x_q     <= 7'd0;
            cand_y_q     <= 7'd0;
            hit_wall_q   <= 1'b0;
            tick_count_q <= 16'd0;
            game_over_q  <= 1'b0;
            updating_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_drawing_q <= is_drawing_d;
            head_x_q     <= head_x_d;
            head_y_q     <= head_y_d;
            dir_q        <= dir_d;
            next_dir_q   <= next_dir_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            hit_wall_q   <= hit_wall_d;
            tick_count_q <= tick_count_d;
            game_over_q  <= game_over_d;
            updating_q   <= updating_d;
        end
    end

    assign headX     = head_x_q;
    assign headY     = head_y_q;
    assign dir       = dir_q;
    assign tickCount = tick_count_q;
    assign gameOver  = game_over_q;
    assign updating  = updating_q;

endmodule

// File: doc/snake_game_tick.md
# snake_game_tick

Frame-boundary consumer for the snake display timing generator. Watches the `isDrawing` frame-gating signal and the 32-bit `rstage` game-stage word. At the end of every drawn frame it runs a short multi-cycle update: latch the requested direction, step the snake head one cell, check for walls, and commit the new state. It is the game-logic side of the frame interface and owns head position, direction, tick count and game-over status.

## Interface
- `GRID_W`, default 40: grid width in cells; legal X is 0..GRID_W-1.
- `GRID_H`, default 30: grid height in cells; legal Y is 0..GRID_H-1.
- `START_X`, default 20: head X after reset or stage-0 reinit.
- `START_Y`, default 15: head Y after reset or stage-0 reinit.
- `PLAY_STAGE`, default 2: stage value that enables movement.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `isDrawing` in 1: frame gate from the timing generator; a 1→0 transition marks a frame end.
- `rstage` in 32: current game stage.
- `dirIn` in 2: requested direction; 0 = up, 1 = right, 2 = down, 3 = left.
- `headX` out 6: current head X.
- `headY` out 6: current head Y.
- `dir` out 2: committed direction.
- `tickCount` out 16: number of committed moves, saturating.
- `gameOver` out 1: sticky wall-collision flag.
- `updating` out 1: high while the FSM is not in IDLE.

## Operation
- **Edge detection.** `isDrawing` is registered into `isDrawingQ`. `frameEnd = isDrawingQ & ~isDrawing`, evaluated only in IDLE.
- **FSM states:** IDLE, LATCH, MOVE, CHECK, COMMIT.
- **IDLE:**
  - On `frameEnd` with `rstage == 0`: reinitialise. Head goes to (START_X, START_Y), `dir` = 1, `tickCount` = 0, `gameOver` = 0. Stay in IDLE.
  - On `frameEnd` with `rstage == PLAY_STAGE` and `gameOver == 0`: go to LATCH.
  - Any other stage value, or `gameOver == 1`: ignore the edge.
- **LATCH:** sample `dirIn` into `nextDir`.
  - If `dirIn == dir ^ 2` (a reversal), `nextDir` = `dir`.
  - Go to MOVE.
- **MOVE:** compute `candX`/`candY` from `nextDir`.
  - Up: Y−1. Down: Y+1. Left: X−1. Right: X+1.
  - Compute at 7 bits so underflow below 0 is detectable.
  - Go to CHECK.
- **CHECK:** `hitWall` = candidate X < 0 or > GRID_W-1, or candidate Y < 0 or > GRID_H-1. Go to COMMIT.
- **COMMIT:**
  - If `hitWall`: set `gameOver` = 1. Head and `dir` are unchanged.
  - Otherwise: head ← candidate, `dir` ← `nextDir`.
  - In both cases `tickCount` increments, saturating at 16'hFFFF.
  - Go to IDLE.
- **Edges while busy.** A `frameEnd` that occurs while not in IDLE is dropped. It is not queued.
- **`dirIn` timing.** Changes to `dirIn` outside the LATCH cycle have no effect.

## Timing
- **Reset values:** `headX` = START_X, `headY` = START_Y, `dir` = 1, `tickCount` = 0, `gameOver` = 0, `updating` = 0, `isDrawingQ` = 0, state = IDLE.
- **Cycle numbering.** Cycle E is the rising edge at which `frameEnd` is sampled high in IDLE.
- **Sequence from E:**
  - At E, the state becomes LATCH.
  - `dirIn` is sampled at E+1.
  - The state becomes IDLE at E+4.
  - `headX`, `headY`, `dir`, `gameOver` and `tickCount` become visible after edge E+4.
- **`updating`.** High from after E through after E+3, i.e. exactly 4 cycles. Low from E+4.
- **Stage-0 reinit** takes effect at edge E. `updating` stays low.
- **Reset mid-operation.** The FSM returns to IDLE immediately and no commit happens. `isDrawingQ` clears, so a low `isDrawing` right after reset does not produce a spurious `frameEnd`.
- **Simultaneous events.** At edge E only `frameEnd` and `rstage` matter. `rstage` changes after E do not abort an update in progress.

## Configuration
- **Macro:** `SNAKE_WRAP_EN`.
- **Defined:** CHECK never flags `hitWall`. MOVE wraps instead:
  - X = −1 → GRID_W-1; X = GRID_W → 0.
  - Y = −1 → GRID_H-1; Y = GRID_H → 0.
  - `gameOver` is constant 0.
- **Undefined:** wall collision sets sticky `gameOver` as described in Operation.

## Test plan
- **Reset.** Assert `reset` mid-frame → all outputs at reset values within the same cycle. After release with `isDrawing` = 0, the FSM stays IDLE.
- **Basic move.** `rstage` = 2, `dirIn` = 1, pulse `isDrawing` 1→0 → `updating` high exactly 4 cycles, then `headX` = 21, `headY` = 15, `tickCount` = 1.
- **Reversal rejection.** Committed `dir` = 1, `dirIn` = 3 at the LATCH cycle → `dir` stays 1 and `headX` increments.
- **Wall collision (macro undefined).** From `headX` = 39 with `dir` = 1, frame end → `gameOver` = 1, `headX` = 39. A further frame end changes nothing. A frame end with `rstage` = 0 restores (20,15) and clears `gameOver` and `tickCount`.
- **Wrap (`SNAKE_WRAP_EN` defined).** From `headY` = 0 with `dir` = 0 → `headY` = 29, `gameOver` = 0.
- **Ignored edges.** Frame end with `rstage` = 1 → no change, `updating` stays 0. A second 1→0 edge 2 cycles after E → dropped, `tickCount` incremented once.
